// File: rtl/program_loader.sv
// Boot loader: parses a little-endian word-count header from the host byte stream,
// assembles 32-bit words, writes them to program memory and reports a status byte.
`ifndef PROGRAM_MEMORY_ADDRESS_BITWIDTH
`define PROGRAM_MEMORY_ADDRESS_BITWIDTH 12
`endif

module program_loader #(
   parameter int ADDRESS_BITWIDTH = `PROGRAM_MEMORY_ADDRESS_BITWIDTH,
   parameter int DEPTH_WORDS      = 2**(ADDRESS_BITWIDTH-2)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic [ADDRESS_BITWIDTH-1:0] write_address,
   output logic [31:0]                 write_data,
   output logic                        write_enable,
   output logic                        cpu_hold,
   output logic                        load_done,
   output logic                        load_error
);

   localparam int         IW    = ADDRESS_BITWIDTH - 1;
   localparam logic [32:0] DEPTH = 33'(DEPTH_WORDS);
   localparam logic [7:0] OK    = 8'hAA;
   localparam logic [7:0] ERR   = 8'hEE;

   typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, STATUS, DONE} state_t;

   state_t        state, state_nxt;
   logic [1:0]    byte_cnt;
   logic [23:0]   shreg;
   logic [31:0]   count;
   logic [IW-1:0] word_idx;
   logic [31:0]   shifted, idx_inc;
   logic          take, last_byte, oversize;

   assign take      = rx_valid && rx_ready;
   assign last_byte = take && (byte_cnt == 2'd3);
   // Incoming byte lands in the MSB; after four bytes byte 0 sits in [7:0].
   assign shifted   = {rx_data, shreg};
   assign oversize  = ({1'b0, shifted} > DEPTH);
   assign idx_inc   = 32'(word_idx) + 32'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = HDR;
         HDR:        if (last_byte) state_nxt = (oversize || shifted == 32'd0) ? STATUS : DATA;
         DATA:       if (last_byte) state_nxt = WRITE;
         WRITE:      state_nxt = (idx_inc == count) ? STATUS : DATA;
         STATUS:     if (tx_ready) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // All outputs are registered from the next-state decode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_ready      <= 1'b0;
         tx_valid      <= 1'b0;
         tx_data       <= 8'h00;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         cpu_hold      <= 1'b0;
         load_done     <= 1'b0;
         load_error    <= 1'b0;
         byte_cnt      <= 2'd0;
         shreg         <= '0;
         count         <= '0;
         word_idx      <= '0;
      end else begin
         rx_ready     <= (state_nxt == HDR) || (state_nxt == DATA);
         write_enable <= (state_nxt == WRITE);
         tx_valid     <= (state_nxt == STATUS);
         cpu_hold     <= (state_nxt == HDR) || (state_nxt == DATA) ||
                         (state_nxt == WRITE) || (state_nxt == STATUS);
         if (take) begin
            shreg    <= shifted[31:8];
            byte_cnt <= byte_cnt + 2'd1;
         end
         if ((state == IDLE || state == DONE) && start) begin
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
         end
         if (state == HDR && last_byte) begin
            count   <= shifted;
            tx_data <= oversize ? ERR : OK;
         end
         if (state == DATA && last_byte) begin
            write_data    <= shifted;
            write_address <= {word_idx[IW-2:0], 2'b00};
         end
         if (state == WRITE) begin
            word_idx <= word_idx + IW'(1);
            if (idx_inc == count) tx_data <= OK;
         end
         if (state == STATUS && tx_ready) begin
            load_done  <= (tx_data == OK);
            load_error <= (tx_data == ERR);
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a queue model of expected writes and status,
// checked every cycle by a negedge monitor, plus literal pins on key loads.
module tb_program_loader;

   localparam int AW    = 6;
   localparam int DEPTH = 16;

   logic        clk = 0, reset_n = 0, start = 0;
   logic [7:0]  rx_data = 0;
   logic        rx_valid = 0, rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready = 0;
   logic [AW-1:0] write_address;
   logic [31:0] write_data;
   logic        write_enable, cpu_hold, load_done, load_error;

   program_loader #(.ADDRESS_BITWIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error));

   always #5 clk = ~clk;

   typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;

   int          n_pass = 0, n_total = 0;
   wr_t         exp_q[$];
   wr_t         wlog[$];
   logic [31:0] prog [0:31];
   logic [7:0]  last_tx;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write must match the head of the expected queue; a pending
   // status byte must not move while the transmitter is stalled.
   logic [7:0] prev_tx_data = 0;
   logic       prev_hold = 0;
   always @(negedge clk) begin
      if (reset_n) begin
         if (write_enable) begin
            if (exp_q.size() == 0) chk("extra_write", 1, 0);
            else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(write_address), 32'(e.a));
               chk("wr_data", write_data, e.d);
            end
            wlog.push_back({write_address, write_data});
            chk("rx_ready_during_write", 32'(rx_ready), 0);
         end
         if (prev_hold) begin
            chk("tx_valid_held", 32'(tx_valid), 1);
            chk("tx_data_stable", 32'(tx_data), 32'(prev_tx_data));
         end
         prev_hold    = tx_valid && !tx_ready;
         prev_tx_data = tx_data;
      end else prev_hold = 0;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget = 0;
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1;
      while (!rx_ready && budget < 100) begin tick(); budget++; end
      if (budget >= 100) chk("rx_timeout", 1, 0);
      tick();
      rx_valid = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
      chk("start_cpu_hold", 32'(cpu_hold), 1);
      chk("start_clr_done", 32'(load_done), 0);
      chk("start_clr_error", 32'(load_error), 0);
      chk("start_rx_ready", 32'(rx_ready), 1);
   endtask

   task automatic wait_status(input logic [7:0] code, input int hold);
      int budget = 0;
      while (!tx_valid && budget < 200) begin tick(); budget++; end
      if (budget >= 200) chk("tx_timeout", 1, 0);
      chk("tx_code", 32'(tx_data), 32'(code));
      chk("status_cpu_hold", 32'(cpu_hold), 1);
      last_tx = tx_data;
      repeat (hold) tick();
      tx_ready = 1;
      tick();
      tx_ready = 0;
      chk("tx_valid_dropped", 32'(tx_valid), 0);
      chk("load_done", 32'(load_done), 32'(code == 8'hAA));
      chk("load_error", 32'(load_error), 32'(code == 8'hEE));
      chk("cpu_hold_released", 32'(cpu_hold), 0);
      chk("done_rx_ready", 32'(rx_ready), 0);
   endtask

   task automatic do_load(input logic [31:0] n, input int gapmax, input int hold, input bit mid_start);
      logic [7:0] code;
      exp_q.delete();
      wlog.delete();
      if (n > DEPTH) code = 8'hEE;
      else begin
         code = 8'hAA;
         for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(i * 4), d: prog[i]});
      end
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), $urandom_range(0, gapmax));
      if (n != 0 && n <= DEPTH)
         for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(prog[i] >> (8 * k)), $urandom_range(0, gapmax));
            if (mid_start && i == 0) begin
               start = 1;
               tick();
               start = 0;
               chk("mid_start_ignored", 32'(cpu_hold), 1);
            end
         end
      wait_status(code, hold);
      chk("writes_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_rx_ready", 32'(rx_ready), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_we", 32'(write_enable), 0);
      chk("rst_addr", 32'(write_address), 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_err", 32'(load_error), 0);
      tick();
      reset_n = 1;
      // A byte offered in IDLE is not taken.
      rx_valid = 1; rx_data = 8'h5A;
      repeat (3) tick();
      chk("idle_rx_ready", 32'(rx_ready), 0);
      rx_valid = 0;

      // Two-instruction program, back to back.
      prog[0] = 32'h00000013;
      prog[1] = 32'h00100093;
      do_load(2, 0, 0, 0);
      chk("lit_wcount", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("lit_a0", 32'(wlog[0].a), 32'h0);
         chk("lit_d0", wlog[0].d, 32'h00000013);
         chk("lit_a1", 32'(wlog[1].a), 32'h4);
         chk("lit_d1", wlog[1].d, 32'h00100093);
      end
      chk("lit_tx_ok", 32'(last_tx), 32'hAA);

      do_load(0, 0, 0, 0);
      chk("n0_no_writes", wlog.size(), 0);

      do_load(DEPTH + 1, 1, 2, 0);
      chk("lit_tx_err", 32'(last_tx), 32'hEE);
      chk("oversize_no_writes", wlog.size(), 0);

      // Upper header bits must not be truncated away.
      do_load(32'h01000002, 0, 0, 0);
      chk("hi_bits_err", 32'(last_tx), 32'hEE);

      for (int i = 0; i < 32; i++) prog[i] = $urandom;
      do_load(DEPTH, 0, 0, 0);
      chk("fill_wcount", wlog.size(), DEPTH);
      if (wlog.size() > 0) chk("fill_last_addr", 32'(wlog[wlog.size()-1].a), 32'h3C);

      do_load(3, 3, 5, 1);
      chk("gaps_wcount", wlog.size(), 3);

      // Reset after six data bytes: one word written, the partial one dropped.
      exp_q.delete();
      wlog.delete();
      exp_q.push_back('{a: AW'(0), d: prog[0]});
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(32'd4 >> (8 * k)), 0);
      for (int b = 0; b < 6; b++) send_byte(8'(prog[b / 4] >> (8 * (b % 4))), 0);
      reset_n = 0;
      #1;
      chk("mid_rst_rx_ready", 32'(rx_ready), 0);
      chk("mid_rst_we", 32'(write_enable), 0);
      chk("mid_rst_addr", 32'(write_address), 0);
      chk("mid_rst_wdata", write_data, 0);
      chk("mid_rst_hold", 32'(cpu_hold), 0);
      chk("mid_rst_tx", 32'(tx_valid), 0);
      chk("mid_rst_wcount", wlog.size(), 1);
      tick();
      reset_n = 1;
      tick();
      chk("post_rst_idle", 32'(rx_ready), 0);
      do_load(3, 1, 1, 0);
      chk("post_rst_wcount", wlog.size(), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader directly upstream of the program memory. Consumes a byte stream from the host serial receiver, parses a word-count header, assembles little-endian 32-bit instruction words and issues one program-memory write per word. Returns a one-byte status to the host serial transmitter and holds the core in reset while loading.

## Interface
- ADDRESS_BITWIDTH, default `PROGRAM_MEMORY_ADDRESS_BITWIDTH`: byte-address width of program memory.
- DEPTH_WORDS, default 2**(ADDRESS_BITWIDTH-2): program-memory capacity in words.
- clk  in  1  single clock; all state on posedge clk.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- rx_data  in  8  byte from serial receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
- tx_data  out  8  status byte to serial transmitter.
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data.
- write_address  out  ADDRESS_BITWIDTH  byte address of the write (word index << 2).
- write_data  out  32  assembled word.
- write_enable  out  1  one-cycle write strobe.
- cpu_hold  out  1  high from start through the end of the status-byte transfer.
- load_done  out  1  level; load finished successfully.
- load_error  out  1  level; header rejected.

## Operation
- States: IDLE, HDR, DATA, WRITE, STATUS, DONE.
- IDLE: rx_ready=0. A start pulse moves to HDR with byte_cnt=0, word_idx=0, and clears load_done/load_error.
- HDR: rx_ready=1. Accepts 4 bytes, little-endian, into 32-bit count N (byte 0 → N[7:0]). After the 4th byte:
  - N > DEPTH_WORDS: go to STATUS, code 0xEE, error flag set.
  - N == 0: go to STATUS, code 0xAA.
  - Otherwise: go to DATA.
- The comparison uses the full 32 bits; N is never truncated.
- DATA: rx_ready=1. Accepts 4 bytes, little-endian, into the word shift register; the 4th byte moves to WRITE.
- WRITE: lasts one cycle.
  - write_enable=1, write_address=word_idx<<2, write_data=assembled word; rx_ready=0.
  - word_idx increments. If word_idx+1 == N, go to STATUS with code 0xAA; otherwise return to DATA.
- STATUS: tx_valid=1 with the code. On tx_ready, go to DONE.
- DONE:
  - load_done=1 if the code was 0xAA; load_error=1 if it was 0xEE.
  - cpu_hold=0, rx_ready=0.
  - A start pulse re-enters HDR and clears both flags.
- start is ignored in HDR, DATA, WRITE and STATUS.
- Bytes offered in IDLE, STATUS and DONE are not accepted; the upstream holds them.
- word_idx is ADDRESS_BITWIDTH-1 bits wide, enough to reach DEPTH_WORDS. write_address upper bits come from word_idx; its low 2 bits are always 0.

## Timing
- Reset values:
  - state=IDLE.
  - rx_ready=0, tx_valid=0, tx_data=0x00.
  - write_enable=0, write_address=0, write_data=0.
  - cpu_hold=0, load_done=0, load_error=0.
- Reset asserted mid-load aborts immediately to IDLE with all outputs at reset values. Words already written stay in memory; no partial word is written.
- cpu_hold rises the cycle after the accepted start pulse. It falls in the cycle after the status handshake completes, which is the same cycle load_done or load_error rises.
- All outputs are registered.
- write_enable is asserted in the cycle after the 4th byte of a word is accepted.
- Throughput: 1 byte/cycle, plus a one-cycle rx_ready bubble per word.
- rx_valid gaps only stall progress; they never corrupt byte ordering.
- tx_data and tx_valid stay stable while tx_ready=0.

## Test plan
- N=2, bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00, back-to-back → writes (0x0,0x00000013) then (0x4,0x00100093); tx 0xAA; load_done=1, cpu_hold=0.
- N=0 → no write_enable; tx 0xAA; load_done=1.
- N=DEPTH_WORDS+1 → no writes; tx 0xEE; load_error=1. Then N=DEPTH_WORDS fills memory; the last write is at address (DEPTH_WORDS-1)<<2.
- Random rx_valid gaps, plus tx_ready held low for 5 cycles → same write sequence; tx_data stable throughout; no extra writes.
- Reset pulsed after 6 data bytes → outputs at reset values, state IDLE; a new start with a full load succeeds.
- start pulsed while in DATA is ignored. start in DONE re-arms: flags clear and cpu_hold=1 on the next cycle.
